core_pipe_mem: RTL and testbench

// Memory stage: sits between execute (s2) and writeback (s3). Buffers one s2 instr, aligns store

---
 rtl/core_pipe_mem_pkg.sv | 41 ++++
 rtl/core_pipe_mem_align.sv | 35 +++
 rtl/core_pipe_mem.sv | 143 ++++++++++++++
 tb/tb_core_pipe_mem.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_mem_pkg.sv
// Shared types and constants for the memory stage: LSU op layout, trap causes,
// FSM states and the record carried from the s2 buffer into the s3 register.
package core_pipe_mem_pkg;
   localparam int XLEN       = 64;
   localparam int MEM_ADDR_W = 64;
   localparam int LSU_OP_W   = 5;
   localparam int CSR_OP_W   = 3;
   localparam int CFU_OP_W   = 3;
   localparam int WB_OP_W    = 2;

   // lsu_op = {load, store, size[1:0], unsigned}; size 0=byte 1=half 2=word 3=double
   localparam int LSU_OP_LOAD    = 4;
   localparam int LSU_OP_STORE   = 3;
   localparam int LSU_OP_SIZE_HI = 2;
   localparam int LSU_OP_SIZE_LO = 1;
   localparam int LSU_OP_UNS     = 0;

   localparam logic [4:0] CAUSE_LDMA = 5'd4;
   localparam logic [4:0] CAUSE_STMA = 5'd6;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_REQ   = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0]     pc;
      logic [XLEN-1:0]     n_pc;
      logic [31:0]         instr;
      logic [XLEN-1:0]     wdata;
      logic [XLEN-1:0]     rs2;
      logic [4:0]          rd;
      logic [LSU_OP_W-1:0] lsu_op;
      logic [CSR_OP_W-1:0] csr_op;
      logic [CFU_OP_W-1:0] cfu_op;
      logic [WB_OP_W-1:0]  wb_op;
      logic [11:0]         csr_addr;
      logic                trap;
   } mem_instr_t;
endpackage

// File: rtl/core_pipe_mem_align.sv
// Store alignment: byte strobes, lane-shifted store data and misalignment
// detection from the access size and low address bits.
module core_pipe_mem_align
   import core_pipe_mem_pkg::*;
(
   input  logic            i_load,
   input  logic            i_store,
   input  logic [1:0]      i_size,
   input  logic [2:0]      i_addr,
   input  logic [XLEN-1:0] i_rs2,
   output logic [7:0]      o_strb,
   output logic [XLEN-1:0] o_wdata,
   output logic            o_misalign
);

   logic [7:0] w_base;
   logic       w_bad;

   always_comb begin
      w_base = 8'h01;
      w_bad  = 1'b0;
      case (i_size)
         2'd0: begin w_base = 8'h01; w_bad = 1'b0;          end
         2'd1: begin w_base = 8'h03; w_bad = i_addr[0];     end
         2'd2: begin w_base = 8'h0F; w_bad = |i_addr[1:0]; end
         2'd3: begin w_base = 8'hFF; w_bad = |i_addr;       end
         default: ;
      endcase
      // Bytes shifted past lane 7 are dropped; misaligned accesses never issue anyway.
      o_strb     = w_base << i_addr;
      o_wdata    = i_rs2 << {i_addr, 3'b000};
      o_misalign = w_bad & (i_load | i_store);
   end

endmodule

// File: rtl/core_pipe_mem.sv
// Memory stage between execute and writeback: one-entry buffer, dmem req/gnt
// issue, misalignment traps and the s3 pipeline register.
module core_pipe_mem
   import core_pipe_mem_pkg::*;
(
   input  logic                  g_clk,
   input  logic                  g_reset,
   input  logic                  s2_flush,
   input  logic                  s2_valid,
   output logic                  s2_ready,
   input  logic [XLEN-1:0]       s2_pc,
   input  logic [XLEN-1:0]       s2_n_pc,
   input  logic [31:0]           s2_instr,
   input  logic [XLEN-1:0]       s2_wdata,
   input  logic [XLEN-1:0]       s2_rs2,
   input  logic [4:0]            s2_rd,
   input  logic [LSU_OP_W-1:0]   s2_lsu_op,
   input  logic [CSR_OP_W-1:0]   s2_csr_op,
   input  logic [CFU_OP_W-1:0]   s2_cfu_op,
   input  logic [WB_OP_W-1:0]    s2_wb_op,
   input  logic [11:0]           s2_csr_addr,
   input  logic                  s2_trap,
   output logic                  s3_valid,
   input  logic                  s3_ready,
   output logic                  s3_full,
   output logic [XLEN-1:0]       s3_pc,
   output logic [XLEN-1:0]       s3_n_pc,
   output logic [31:0]           s3_instr,
   output logic [XLEN-1:0]       s3_wdata,
   output logic [XLEN-1:0]       s3_rs2,
   output logic [4:0]            s3_rd,
   output logic [LSU_OP_W-1:0]   s3_lsu_op,
   output logic [CSR_OP_W-1:0]   s3_csr_op,
   output logic [CFU_OP_W-1:0]   s3_cfu_op,
   output logic [WB_OP_W-1:0]    s3_wb_op,
   output logic [11:0]           s3_csr_addr,
   output logic                  s3_trap,
   output logic                  dmem_req,
   output logic [MEM_ADDR_W-1:0] dmem_addr,
   output logic                  dmem_wen,
   output logic [7:0]            dmem_strb,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic                  dmem_gnt
);

   state_e          r_state, w_state_nxt, w_acc_state;
   mem_instr_t      r_buf, r_s3, w_new;
   logic [7:0]      r_strb, w_strb;
   logic [XLEN-1:0] r_wdata_al, w_wdata_al;
   logic            r_s3_full;
   logic            w_misalign, w_is_lsu, w_fire, w_accept, w_s3_valid;

   core_pipe_mem_align u_align (
      .i_load     (s2_lsu_op[LSU_OP_LOAD]),
      .i_store    (s2_lsu_op[LSU_OP_STORE]),
      .i_size     (s2_lsu_op[LSU_OP_SIZE_HI:LSU_OP_SIZE_LO]),
      .i_addr     (s2_wdata[2:0]),
      .i_rs2      (s2_rs2),
      .o_strb     (w_strb),
      .o_wdata    (w_wdata_al),
      .o_misalign (w_misalign)
   );

   assign w_is_lsu   = s2_lsu_op[LSU_OP_LOAD] | s2_lsu_op[LSU_OP_STORE];
   assign w_s3_valid = (r_state == ST_HOLD) || ((r_state == ST_REQ) && dmem_gnt);
   assign w_fire     = w_s3_valid && s3_ready;
   assign s2_ready   = (r_state == ST_EMPTY) || w_fire;
   assign w_accept   = s2_valid && s2_ready && !s2_flush;

   // An upstream trap keeps its own cause; only clean LSU ops can raise a misalign trap.
   always_comb begin
      w_new = '{pc: s2_pc, n_pc: s2_n_pc, instr: s2_instr, wdata: s2_wdata, rs2: s2_rs2,
                rd: s2_rd, lsu_op: s2_lsu_op, csr_op: s2_csr_op, cfu_op: s2_cfu_op,
                wb_op: s2_wb_op, csr_addr: s2_csr_addr, trap: s2_trap};
      w_acc_state = ST_HOLD;
      if (!s2_trap && w_misalign) begin
         w_new.trap = 1'b1;
         w_new.rd   = s2_lsu_op[LSU_OP_LOAD] ? CAUSE_LDMA : CAUSE_STMA;
      end else if (!s2_trap && w_is_lsu) begin
         w_acc_state = ST_REQ;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (s2_flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = w_acc_state;
            ST_HOLD, ST_REQ:
               if (w_fire) w_state_nxt = w_accept ? w_acc_state : ST_EMPTY;
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_state    <= ST_EMPTY;
         r_buf      <= '0;
         r_strb     <= '0;
         r_wdata_al <= '0;
         r_s3       <= '0;
         r_s3_full  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_buf      <= w_new;
            r_strb     <= w_strb;
            r_wdata_al <= w_wdata_al;
         end
         if (s2_flush) begin
            r_s3_full <= 1'b0;
         end else if (w_fire) begin
            r_s3      <= r_buf;
            r_s3_full <= 1'b1;
         end
      end
   end

   assign s3_valid    = w_s3_valid;
   assign s3_full     = r_s3_full;
   assign dmem_req    = (r_state == ST_REQ) && s3_ready;
   assign dmem_addr   = {r_buf.wdata[XLEN-1:3], 3'b000};
   assign dmem_wen    = r_buf.lsu_op[LSU_OP_STORE];
   assign dmem_strb   = r_strb;
   assign dmem_wdata  = r_wdata_al;

   assign s3_pc       = r_s3.pc;
   assign s3_n_pc     = r_s3.n_pc;
   assign s3_instr    = r_s3.instr;
   assign s3_wdata    = r_s3.wdata;
   assign s3_rs2      = r_s3.rs2;
   assign s3_rd       = r_s3.rd;
   assign s3_lsu_op   = r_s3.lsu_op;
   assign s3_csr_op   = r_s3.csr_op;
   assign s3_cfu_op   = r_s3.cfu_op;
   assign s3_wb_op    = r_s3.wb_op;
   assign s3_csr_addr = r_s3.csr_addr;
   assign s3_trap     = r_s3.trap;

endmodule

// File: tb/tb_core_pipe_mem.sv
// Directed bench for core_pipe_mem: ALU streaming, store alignment, misalign
// traps, grant stalls, writeback backpressure, flush and reset behaviour.
module tb_core_pipe_mem;
   import core_pipe_mem_pkg::*;

   logic                  g_clk = 1'b0;
   logic                  g_reset, s2_flush, s2_valid, s2_ready;
   logic [XLEN-1:0]       s2_pc, s2_n_pc, s2_wdata, s2_rs2;
   logic [31:0]           s2_instr;
   logic [4:0]            s2_rd;
   logic [LSU_OP_W-1:0]   s2_lsu_op;
   logic [CSR_OP_W-1:0]   s2_csr_op;
   logic [CFU_OP_W-1:0]   s2_cfu_op;
   logic [WB_OP_W-1:0]    s2_wb_op;
   logic [11:0]           s2_csr_addr;
   logic                  s2_trap;
   logic                  s3_valid, s3_ready, s3_full, s3_trap;
   logic [XLEN-1:0]       s3_pc, s3_n_pc, s3_wdata, s3_rs2;
   logic [31:0]           s3_instr;
   logic [4:0]            s3_rd;
   logic [LSU_OP_W-1:0]   s3_lsu_op;
   logic [CSR_OP_W-1:0]   s3_csr_op;
   logic [CFU_OP_W-1:0]   s3_cfu_op;
   logic [WB_OP_W-1:0]    s3_wb_op;
   logic [11:0]           s3_csr_addr;
   logic                  dmem_req, dmem_wen, dmem_gnt;
   logic [MEM_ADDR_W-1:0] dmem_addr;
   logic [7:0]            dmem_strb;
   logic [XLEN-1:0]       dmem_wdata;

   int n_chk  = 0;
   int n_pass = 0;

   // lsu_op = {load, store, size, unsigned}
   localparam logic [4:0] OP_NONE = 5'b00000;
   localparam logic [4:0] OP_SB   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b01100;
   localparam logic [4:0] OP_SD   = 5'b01110;
   localparam logic [4:0] OP_LH   = 5'b10010;
   localparam logic [4:0] OP_LW   = 5'b10100;
   localparam logic [4:0] OP_LD   = 5'b10110;

   core_pipe_mem dut (
      .g_clk(g_clk), .g_reset(g_reset), .s2_flush(s2_flush), .s2_valid(s2_valid),
      .s2_ready(s2_ready), .s2_pc(s2_pc), .s2_n_pc(s2_n_pc), .s2_instr(s2_instr),
      .s2_wdata(s2_wdata), .s2_rs2(s2_rs2), .s2_rd(s2_rd), .s2_lsu_op(s2_lsu_op),
      .s2_csr_op(s2_csr_op), .s2_cfu_op(s2_cfu_op), .s2_wb_op(s2_wb_op),
      .s2_csr_addr(s2_csr_addr), .s2_trap(s2_trap), .s3_valid(s3_valid),
      .s3_ready(s3_ready), .s3_full(s3_full), .s3_pc(s3_pc), .s3_n_pc(s3_n_pc),
      .s3_instr(s3_instr), .s3_wdata(s3_wdata), .s3_rs2(s3_rs2), .s3_rd(s3_rd),
      .s3_lsu_op(s3_lsu_op), .s3_csr_op(s3_csr_op), .s3_cfu_op(s3_cfu_op),
      .s3_wb_op(s3_wb_op), .s3_csr_addr(s3_csr_addr), .s3_trap(s3_trap),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
      .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic put(input logic v, input logic [63:0] addr, input logic [63:0] rs2,
                      input logic [4:0] rd, input logic [4:0] lsu, input logic trap);
      s2_valid  = v;
      s2_wdata  = addr;
      s2_pc     = addr + 64'h8000;
      s2_n_pc   = addr + 64'h8004;
      s2_rs2    = rs2;
      s2_rd     = rd;
      s2_lsu_op = lsu;
      s2_trap   = trap;
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   initial begin
      g_reset = 1'b1; s2_flush = 1'b0; s3_ready = 1'b1; dmem_gnt = 1'b0;
      s2_instr = 32'h0000_0013; s2_csr_op = '0; s2_cfu_op = '0; s2_wb_op = '0;
      s2_csr_addr = '0;
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      step(); step();
      g_reset = 1'b0;
      #1;
      chk("rst_s2_ready", 64'(s2_ready), 64'd1);
      chk("rst_s3_valid", 64'(s3_valid), 64'd0);
      chk("rst_dmem_req", 64'(dmem_req), 64'd0);
      chk("rst_s3_full",  64'(s3_full),  64'd0);
      chk("rst_s3_pc",    s3_pc,         64'd0);

      // Back-to-back ALU ops: one retired into s3 every cycle
      for (int k = 0; k < 5; k++) begin
         put(k < 4, 64'h100 + 64'(k), 64'h0, 5'd1, OP_NONE, 1'b0);
         #1;
         if (k > 0) begin
            chk("alu_s3_valid", 64'(s3_valid), 64'd1);
            chk("alu_no_req",   64'(dmem_req), 64'd0);
            chk("alu_s2_ready", 64'(s2_ready), 64'd1);
         end
         step();
         if (k > 0) chk("alu_s3_wdata", s3_wdata, 64'h100 + 64'(k - 1));
      end
      chk("alu_s3_full", 64'(s3_full), 64'd1);

      // SW to upper word of a doubleword
      put(1'b1, 64'h1004, 64'hDEADBEEF, 5'd0, OP_SW, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("sw_req",   64'(dmem_req),  64'd1);
      chk("sw_addr",  dmem_addr,      64'h1000);
      chk("sw_strb",  64'(dmem_strb), 64'hF0);
      chk("sw_wdata", dmem_wdata,     64'hDEADBEEF_00000000);
      chk("sw_wen",   64'(dmem_wen),  64'd1);
      dmem_gnt = 1'b1;
      #1;
      chk("sw_gnt_s3_valid", 64'(s3_valid), 64'd1);
      step();
      dmem_gnt = 1'b0;
      chk("sw_s3_wdata", s3_wdata,       64'h1004);
      chk("sw_s3_lsu",   64'(s3_lsu_op), 64'(OP_SW));

      // Misaligned LH and SD trap without a request
      put(1'b1, 64'h2003, 64'h0, 5'd9, OP_LH, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("lh_no_req",   64'(dmem_req), 64'd0);
      chk("lh_s3_valid", 64'(s3_valid), 64'd1);
      step();
      chk("lh_trap", 64'(s3_trap), 64'd1);
      chk("lh_rd",   64'(s3_rd),   64'd4);
      put(1'b1, 64'h2004, 64'h55, 5'd9, OP_SD, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("sd_no_req", 64'(dmem_req), 64'd0);
      step();
      chk("sd_trap", 64'(s3_trap), 64'd1);
      chk("sd_rd",   64'(s3_rd),   64'd6);

      // Upstream trap on aligned LW: passes through untouched, no request
      put(1'b1, 64'h2008, 64'h0, 5'd2, OP_LW, 1'b1);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("utrap_no_req", 64'(dmem_req), 64'd0);
      step();
      chk("utrap_trap", 64'(s3_trap), 64'd1);
      chk("utrap_rd",   64'(s3_rd),   64'd2);

      // LD with grant held off for three cycles
      put(1'b1, 64'h3008, 64'h0, 5'd7, OP_LD, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("ld_wait_req",      64'(dmem_req), 64'd1);
         chk("ld_wait_s2_ready", 64'(s2_ready), 64'd0);
         chk("ld_wait_s3_valid", 64'(s3_valid), 64'd0);
         step();
      end
      dmem_gnt = 1'b1;
      #1;
      chk("ld_gnt_s3_valid", 64'(s3_valid),  64'd1);
      chk("ld_gnt_s2_ready", 64'(s2_ready),  64'd1);
      chk("ld_strb",         64'(dmem_strb), 64'hFF);
      chk("ld_wen",          64'(dmem_wen),  64'd0);
      step();
      dmem_gnt = 1'b0;
      #1;
      chk("ld_s3_wdata", s3_wdata,      64'h3008);
      chk("ld_s3_rd",    64'(s3_rd),    64'd7);
      chk("ld_s3_trap",  64'(s3_trap),  64'd0);
      chk("ld_done_req", 64'(dmem_req), 64'd0);

      // LW with writeback stalled: request withheld until s3_ready
      s3_ready = 1'b0;
      put(1'b1, 64'h4000, 64'h0, 5'd3, OP_LW, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("lw_stall_req", 64'(dmem_req), 64'd0);
      step();
      s3_ready = 1'b1;
      #1;
      chk("lw_ready_req", 64'(dmem_req), 64'd1);
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      chk("lw_s3_wdata", s3_wdata, 64'h4000);

      // SB then flush while waiting for grant
      put(1'b1, 64'h5003, 64'hAB, 5'd0, OP_SB, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("sb_req",   64'(dmem_req),  64'd1);
      chk("sb_strb",  64'(dmem_strb), 64'h08);
      chk("sb_wdata", dmem_wdata,     64'hAB00_0000);
      s2_flush = 1'b1;
      step();
      s2_flush = 1'b0;
      #1;
      chk("flush_req",      64'(dmem_req), 64'd0);
      chk("flush_s3_full",  64'(s3_full),  64'd0);
      chk("flush_s2_ready", 64'(s2_ready), 64'd1);
      chk("flush_s3_valid", 64'(s3_valid), 64'd0);

      // Flush coinciding with grant: s3 keeps its previous contents
      put(1'b1, 64'h7000, 64'h0, 5'd5, OP_LW, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      dmem_gnt = 1'b1; s2_flush = 1'b1;
      step();
      dmem_gnt = 1'b0; s2_flush = 1'b0;
      #1;
      chk("flgnt_s3_wdata", s3_wdata,       64'h4000);
      chk("flgnt_s3_full",  64'(s3_full),   64'd0);
      chk("flgnt_req",      64'(dmem_req),  64'd0);

      // Reset while a request is outstanding
      put(1'b1, 64'h6000, 64'h0, 5'd8, OP_LD, 1'b0);
      step();
      put(1'b0, 64'h0, 64'h0, 5'd0, OP_NONE, 1'b0);
      #1;
      chk("rreq_req", 64'(dmem_req), 64'd1);
      g_reset = 1'b1;
      step();
      g_reset = 1'b0;
      #1;
      chk("rreq_req_drop", 64'(dmem_req), 64'd0);
      chk("rreq_s3_full",  64'(s3_full),  64'd0);
      chk("rreq_s3_pc",    s3_pc,         64'd0);
      chk("rreq_s3_wdata", s3_wdata,      64'd0);
      chk("rreq_s2_ready", 64'(s2_ready), 64'd1);
      chk("rreq_s3_valid", 64'(s3_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
